recirc_demux_lanes: RTL

- Registered, multi-lane successor to the single-lane combinational recirculation demux.
- Sits ahead of the striping demux. Each cycle it forwards the lane bundle downstream when `active_in` (the downstream-ready AND) is high; otherwise it returns the bundle on the recirculation path.
- Adds per-lane valid qualification and a routing FSM.
- Adds a consecutive-recirculation counter with saturation and a sticky overflow flag for stalled-downstream detection.

---
 rtl/pcie_recirc_pkg.sv | 13 +
 rtl/recirc_lane_route.sv | 45 ++++
 rtl/recirc_demux_lanes.sv | 79 +++++++
 3 files changed

// File: rtl/pcie_recirc_pkg.sv
// Shared definitions for the recirculation demux: FSM state encoding and default lane geometry.
package pcie_recirc_pkg;

    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_LANES  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FWD    = 2'd1,
        ST_RECIRC = 2'd2
    } state_e;

endpackage

// File: rtl/recirc_lane_route.sv
// One lane of the registered 1-to-2 router: steers a valid word to the forward or recirculation side.
module recirc_lane_route
    import pcie_recirc_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [DATA_W-1:0] din,
    input  logic              valid_in,
    input  logic              active_in,
    output logic [DATA_W-1:0] out_demux,
    output logic              valid_demux,
    output logic [DATA_W-1:0] out_block,
    output logic              valid_block
);

    logic [DATA_W-1:0] data_gated;
    logic [DATA_W-1:0] demux_d, block_d;
    logic              vdemux_d, vblock_d;

    // Gate data on valid so an invalid lane never leaks din (including X) to either side.
    always_comb begin
        data_gated = valid_in ? din : '0;
        demux_d    = active_in ? data_gated : '0;
        block_d    = active_in ? '0 : data_gated;
        vdemux_d   = valid_in & active_in;
        vblock_d   = valid_in & ~active_in;
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            out_demux   <= '0;
            valid_demux <= 1'b0;
            out_block   <= '0;
            valid_block <= 1'b0;
        end else begin
            out_demux   <= demux_d;
            valid_demux <= vdemux_d;
            out_block   <= block_d;
            valid_block <= vblock_d;
        end
    end

endmodule

// File: rtl/recirc_demux_lanes.sv
// Multi-lane registered recirculation demux with routing FSM, saturating recirculation streak
// counter and sticky overflow flag for stalled-downstream detection.
module recirc_demux_lanes
    import pcie_recirc_pkg::*;
#(
    parameter int unsigned DATA_W     = DEF_DATA_W,
    parameter int unsigned LANES      = DEF_LANES,
    parameter int unsigned MAX_RECIRC = 8,
    localparam int unsigned CNT_W     = $clog2(MAX_RECIRC + 1)
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [LANES*DATA_W-1:0] din,
    input  logic [LANES-1:0]        valid_in,
    input  logic                    active_in,
    output logic [LANES*DATA_W-1:0] out_demux,
    output logic [LANES-1:0]        valid_demux,
    output logic [LANES*DATA_W-1:0] out_block,
    output logic [LANES-1:0]        valid_block,
    output logic [CNT_W-1:0]        recirc_cnt,
    output logic                    overflow,
    output logic [1:0]              state
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_RECIRC);

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        recirc_lane_route #(.DATA_W(DATA_W)) u_route (
            .clk         (clk),
            .reset_L     (reset_L),
            .din         (din[g*DATA_W +: DATA_W]),
            .valid_in    (valid_in[g]),
            .active_in   (active_in),
            .out_demux   (out_demux[g*DATA_W +: DATA_W]),
            .valid_demux (valid_demux[g]),
            .out_block   (out_block[g*DATA_W +: DATA_W]),
            .valid_block (valid_block[g])
        );
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             any_valid;

    // Idle cycles hold the streak; only a forward with at least one valid lane clears it.
    always_comb begin
        state_d   = ST_IDLE;
        cnt_d     = cnt_q;
        any_valid = |valid_in;
        if (any_valid && active_in) begin
            state_d = ST_FWD;
            cnt_d   = '0;
        end else if (any_valid) begin
            state_d = ST_RECIRC;
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        ovf_d = ovf_q | (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign recirc_cnt = cnt_q;
    assign overflow   = ovf_q;
    assign state      = state_q;

endmodule
